// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-approach stoplight sequencer with all-red clearance and pedestrian WALK
module intersection_ctrl #(
    parameter int TW         = 5,
    parameter int MIN_GREEN  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int PED_CYC    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       car_a,
    input  logic       car_b,
    input  logic       ped_req,
    output logic       a_r,
    output logic       a_y,
    output logic       a_g,
    output logic       b_r,
    output logic       b_y,
    output logic       b_g,
    output logic       walk,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        ALLRED_A = 3'd0,
        A_GRN    = 3'd1,
        A_YEL    = 3'd2,
        ALLRED_B = 3'd3,
        B_GRN    = 3'd4,
        B_YEL    = 3'd5,
        WALK_A   = 3'd6,
        WALK_B   = 3'd7
    } state_t;

    localparam logic [TW-1:0] T_MAX = '1;
    localparam logic [TW-1:0] T_GRN = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_YEL = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] T_AR  = TW'(ALLRED_CYC - 1);
    localparam logic [TW-1:0] T_PED = TW'(PED_CYC - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ped_pend_q, ped_pend_d;
    logic          in_walk, to_walk;

    // next state, phase timer and pedestrian latch
    always_comb begin
        state_d = state_q;
        case (state_q)
            ALLRED_A: if (timer_q >= T_AR) state_d = !en ? ALLRED_A : ped_pend_q ? WALK_A : A_GRN;
            WALK_A:   if (timer_q >= T_PED) state_d = A_GRN;
            A_GRN:    if (timer_q >= T_GRN && (car_b || ped_pend_q || !en)) state_d = A_YEL;
            A_YEL:    if (timer_q >= T_YEL) state_d = ALLRED_B;
            ALLRED_B: if (timer_q >= T_AR) state_d = !en ? ALLRED_B : ped_pend_q ? WALK_B : B_GRN;
            WALK_B:   if (timer_q >= T_PED) state_d = B_GRN;
            B_GRN:    if (timer_q >= T_GRN && (car_a || ped_pend_q || !en)) state_d = B_YEL;
            B_YEL:    if (timer_q >= T_YEL) state_d = ALLRED_A;
            default:  state_d = ALLRED_A;
        endcase
        in_walk    = (state_q == WALK_A) || (state_q == WALK_B);
        to_walk    = (state_d == WALK_A) || (state_d == WALK_B);
        timer_d    = (state_d != state_q) ? '0 : (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;
        ped_pend_d = to_walk ? 1'b0 : in_walk ? ped_pend_q : (ped_pend_q | ped_req);
    end

    // state, timer and request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ALLRED_A;
            timer_q    <= '0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    assign a_g   = (state_q == A_GRN);
    assign a_y   = (state_q == A_YEL);
    assign a_r   = !(a_g || a_y);
    assign b_g   = (state_q == B_GRN);
    assign b_y   = (state_q == B_YEL);
    assign b_r   = !(b_g || b_y);
    assign walk  = (state_q == WALK_A) || (state_q == WALK_B);
    assign phase = state_q;
endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed and random checks of the intersection sequencer
module tb_intersection_ctrl;
    logic       clk = 1'b0;
    logic       rst, en, car_a, car_b, ped_req;
    logic       a_r, a_y, a_g, b_r, b_y, b_g, walk;
    logic [2:0] phase;
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;

    intersection_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .car_a(car_a), .car_b(car_b), .ped_req(ped_req),
        .a_r(a_r), .a_y(a_y), .a_g(a_g), .b_r(b_r), .b_y(b_y), .b_g(b_g),
        .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    // lamp vector {a_r,a_y,a_g,b_r,b_y,b_g,walk}
    function automatic int exp_lamps(int p);
        return {27'd0, !(p == 1 || p == 2), p == 2, p == 1, !(p == 4 || p == 5), p == 5, p == 4, p >= 6};
    endfunction

    function automatic int lamps();
        return {25'd0, a_r, a_y, a_g, b_r, b_y, b_g, walk};
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic at(input int c);
        while (cyc < c) step();
    endtask

    task automatic reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic exp_phase(input string tag, input int c, input int p);
        at(c);
        chk(tag, int'(phase), p);
        chk({tag, "_lamps"}, lamps(), exp_lamps(p));
    endtask

    initial begin
        int prev, len, viol;
        rst = 1'b0; en = 1'b1; car_a = 1'b0; car_b = 1'b0; ped_req = 1'b0;

        // idle: rest in A green
        reset();
        exp_phase("t1_c0", 0, 0);
        exp_phase("t1_c1", 1, 0);
        exp_phase("t1_c2", 2, 1);
        exp_phase("t1_c30", 30, 1);

        // car on B forces handover after minimum green
        reset();
        at(4); car_b = 1'b1;
        exp_phase("t2_c9", 9, 1);
        exp_phase("t2_c10", 10, 2);
        exp_phase("t2_c12", 12, 2);
        exp_phase("t2_c13", 13, 3);
        exp_phase("t2_c14", 14, 3);
        exp_phase("t2_c15", 15, 4);
        car_b = 1'b0;

        // pedestrian pulse gives WALK after A yellow
        reset();
        at(5); ped_req = 1'b1;
        step(); ped_req = 1'b0;
        exp_phase("t3_c9", 9, 1);
        exp_phase("t3_c10", 10, 2);
        exp_phase("t3_c13", 13, 3);
        exp_phase("t3_c15", 15, 7);
        exp_phase("t3_c19", 19, 7);
        exp_phase("t3_c20", 20, 4);
        exp_phase("t3_c30", 30, 4);

        // en=0 parks in ALLRED_B, resume goes to B green next cycle
        reset();
        at(3); en = 1'b0;
        exp_phase("t4_c9", 9, 1);
        exp_phase("t4_c10", 10, 2);
        exp_phase("t4_c13", 13, 3);
        exp_phase("t4_c40", 40, 3);
        en = 1'b1;
        exp_phase("t4_c41", 41, 4);

        // reset during B yellow
        reset();
        car_b = 1'b1;
        at(15); car_a = 1'b1;
        exp_phase("t5_c23", 23, 5);
        at(24);
        car_a = 1'b0; car_b = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        exp_phase("t5_rst", 0, 0);
        exp_phase("t5_c1", 1, 0);
        exp_phase("t5_c2", 2, 1);

        // random traffic: safety and phase durations
        reset();
        prev = int'(phase);
        len = 0;
        for (int i = 0; i < 10000; i++) begin
            car_a   = ($urandom_range(0, 3) == 0);
            car_b   = ($urandom_range(0, 3) == 0);
            ped_req = ($urandom_range(0, 15) == 0);
            en      = ($urandom_range(0, 19) != 0);
            viol = int'(((a_g | a_y) & (b_g | b_y)) | (walk & !(a_r & b_r)));
            chk("safety", viol, 0);
            chk("onehot", int'($countones({a_r, a_y, a_g}) == 1 && $countones({b_r, b_y, b_g}) == 1), 1);
            if (int'(phase) == prev) len++;
            else begin
                if (prev == 1 || prev == 4) chk("green_len", int'(len >= 8), 1);
                if (prev == 2 || prev == 5) chk("yellow_len", len, 3);
                if (prev == 0 || prev == 3) chk("allred_len", int'(len >= 2), 1);
                if (prev >= 6) chk("walk_len", len, 5);
                prev = int'(phase);
                len = 1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
